frame_bbox_tracker: RTL and testbench
=====================================

# frame_bbox_tracker

Per-frame foreground locator on the camera pixel stream, between the camera front end's `rgb_data_src`/`set_x`/`set_y` output and the overlay/recognition video generator. It does four things:
- computes luma per pixel;
- binarizes dark (ink) pixels against a threshold;
- accumulates the bounding box and pixel count of foreground pixels over each frame;
- publishes the frame result with a one-cycle valid pulse for the overlay and recognition logic.

## Interface
Parameters:
- H_ACTIVE, 1280, active pixels per line
- V_ACTIVE, 720, active lines per frame
- LUMA_TH, 96, pixel is foreground when luma < LUMA_TH (8-bit)
- MIN_COUNT, 16, frames with fewer foreground pixels are reported empty

Ports:
- i_clk  in  1  pixel clock
- i_rst  in  1  asynchronous, active-high reset
- i_de  in  1  pixel valid qualifier
- i_x  in  11  pixel column (set_x convention)
- i_y  in  10  pixel row (set_y convention)
- i_rgb  in  24  pixel {R[23:16],G[15:8],B[7:0]}
- o_bin_de  out  1  binarized pixel valid
- o_bin  out  1  1 = foreground
- o_bin_x  out  11  column of o_bin pixel
- o_bin_y  out  10  row of o_bin pixel
- o_box_valid  out  1  one-cycle pulse, frame result updated
- o_box_empty  out  1  last frame had count < MIN_COUNT
- o_x_min, o_x_max  out  11  last frame bounding box columns
- o_y_min, o_y_max  out  10  last frame bounding box rows
- o_pix_count  out  20  last frame foreground pixel count

## Operation
**Pipeline**
- Stage 0 registers de, x, y, rgb, plus flags `first = (x==0 && y==0)` and `last = (x==H_ACTIVE-1 && y==V_ACTIVE-1)`.
- Stage 1 computes `luma = (77*R + 150*G + 29*B) >> 8`. The sum is 16 bits; the result is 8 bits.
- Stage 2 compares `luma < LUMA_TH`, drives the o_bin* outputs and updates the accumulators.
- Pixels with i_de=0, x>=H_ACTIVE or y>=V_ACTIVE are bubbles: o_bin_de=0, no accumulation.

**Accumulators**
- Registers: xmin, xmax, ymin, ymax, count.
- Init values: xmin=H_ACTIVE-1, ymin=V_ACTIVE-1, xmax=0, ymax=0, count=0.
- Each foreground pixel: xmin=min, xmax=max, ymin=min, ymax=max, count+1.
- Count never overflows: 1280*720 < 2^20.

**States**
- States: WAIT_SOF (after reset) and TRACK.
- WAIT_SOF -> TRACK on a valid `first` pixel reaching stage 2. That pixel is accumulated.
- In WAIT_SOF, o_bin* still operate but accumulators stay at init. A `last` pixel in WAIT_SOF produces no result, so no partial frame is ever reported.

**Frame close** (in TRACK, when a valid `last` pixel reaches stage 2):
- Merge that pixel into the accumulators and write the merged values to the output registers.
- Pulse o_box_valid.
- Reset the accumulators to init in the same edge.
- o_box_empty = (merged count < MIN_COUNT). When empty, o_x_min, o_x_max, o_y_min and o_y_max are 0; o_pix_count still carries the true count.

**Out-of-order frame start**
- If a valid `first` pixel arrives in TRACK before `last`, the accumulators restart from that pixel alone. This covers a dropped frame tail.
- The aborted frame is discarded with no pulse.

**Hold behaviour**
- Result outputs hold until the next frame close.

## Timing
- Reset (async assert, clears on the next edge region): every output 0, accumulators init, state WAIT_SOF.
- Pixel presented in cycle c appears on o_bin_de, o_bin, o_bin_x and o_bin_y in cycle c+3.
- For the `last` pixel presented in cycle c, o_box_valid is high for exactly cycle c+3, and the result outputs are valid from c+3.
- Back-to-back frames: a `first` pixel presented in cycle c+1 is accumulated into the fresh frame with no loss. Frame close and clear happen in one edge, so there is no dead cycle.
- Throughput: one pixel per clock. i_de may drop for any number of cycles without affecting results.
- Reset asserted mid-frame aborts the frame. No pulse is generated until one full frame (first...last) is seen after release.

## Test plan
- **Reset behaviour:** assert i_rst mid-stream with any traffic -> all outputs 0 next cycle; first frame after release yields exactly one o_box_valid, at its `last` pixel +3 cycles.
- **Block of dark pixels:** 1280x720 frame, white (FFFFFF) except a black 0x000000 block at x=100..199, y=50..89 -> o_x_min=100, o_x_max=199, o_y_min=50, o_y_max=89, o_pix_count=4000, o_box_empty=0.
- **Threshold edge:** pixel 0x606060 (luma 96) and pixel 0x5F5F5F (luma 95) -> o_bin=0 and o_bin=1 respectively, each 3 cycles after input.
- **Noise rejection:** frame with 15 isolated dark pixels -> o_box_valid pulse, o_box_empty=1, coords 0, o_pix_count=15; repeat with 16 dark pixels -> empty=0.
- **Back-to-back frames with bubbles:** two frames, box A then box B, i_de toggled randomly, no gap between frames -> two pulses, second reports only box B.
- **Truncated frame:** frame truncated at y=300, followed by a full frame with `first` -> no pulse for the truncated frame; correct single result for the full frame.

Source files
------------

// File: rtl/frame_bbox_tracker.sv
// frame_bbox_tracker: per-frame foreground bounding box on the camera pixel stream.
// Three-stage pipeline: capture/qualify, luma, threshold plus accumulate.
// Accumulators are merged at frame close and published with a one-cycle pulse.
module frame_bbox_tracker #(
  parameter int H_ACTIVE  = 1280,
  parameter int V_ACTIVE  = 720,
  parameter int LUMA_TH   = 96,
  parameter int MIN_COUNT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_de,
  input  logic [10:0] i_x,
  input  logic [9:0]  i_y,
  input  logic [23:0] i_rgb,
  output logic        o_bin_de,
  output logic        o_bin,
  output logic [10:0] o_bin_x,
  output logic [9:0]  o_bin_y,
  output logic        o_box_valid,
  output logic        o_box_empty,
  output logic [10:0] o_x_min,
  output logic [10:0] o_x_max,
  output logic [9:0]  o_y_min,
  output logic [9:0]  o_y_max,
  output logic [19:0] o_pix_count
);

  localparam logic [10:0] X_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [8:0]  TH      = 9'(LUMA_TH);
  localparam logic [19:0] MIN_CNT = 20'(MIN_COUNT);

  typedef enum logic {WAIT_SOF, TRACK} state_t;

  typedef struct packed {
    logic [10:0] xmin;
    logic [10:0] xmax;
    logic [9:0]  ymin;
    logic [9:0]  ymax;
    logic [19:0] cnt;
  } box_t;

  // Empty box: min at the far corner, max at origin, so the first merge wins both.
  localparam box_t BOX_INIT = {X_LAST, 11'd0, Y_LAST, 10'd0, 20'd0};

  // Valid bits for stage 0 and stage 1.
  logic [1:0]  vld_pipe_q;

  // Stage 0 payload.
  logic [10:0] s0_x_q;
  logic [9:0]  s0_y_q;
  logic [23:0] s0_rgb_q;
  logic        s0_first_q, s0_last_q;

  // Stage 1 payload.
  logic [10:0] s1_x_q;
  logic [9:0]  s1_y_q;
  logic [7:0]  s1_luma_q;
  logic        s1_first_q, s1_last_q;

  logic        s0_vld_d, s0_first_d, s0_last_d;
  logic [15:0] luma_sum;

  // Frame state and accumulators.
  state_t      state_q, state_d;
  box_t        acc_q, acc_d;
  box_t        base, merged;
  logic        fg, sof, eof, close;

  // Output registers.
  logic        bin_de_q, bin_q;
  logic [10:0] bin_x_q;
  logic [9:0]  bin_y_q;
  logic        box_valid_q, box_valid_d;
  logic        box_empty_q, box_empty_d;
  logic [10:0] x_min_q, x_min_d, x_max_q, x_max_d;
  logic [9:0]  y_min_q, y_min_d, y_max_q, y_max_d;
  logic [19:0] pix_count_q, pix_count_d;

  // Stage 0 qualification and stage 1 luma arithmetic (sum fits 16 bits: 256*255).
  always_comb begin
    s0_vld_d   = i_de && (i_x <= X_LAST) && (i_y <= Y_LAST);
    s0_first_d = (i_x == 11'd0) && (i_y == 10'd0);
    s0_last_d  = (i_x == X_LAST) && (i_y == Y_LAST);
    luma_sum   = 16'd77  * {8'd0, s0_rgb_q[23:16]}
               + 16'd150 * {8'd0, s0_rgb_q[15:8]}
               + 16'd29  * {8'd0, s0_rgb_q[7:0]};
  end

  // Stage 2: threshold and merge the pixel into the running (or restarted) box.
  always_comb begin
    fg   = vld_pipe_q[1] && ({1'b0, s1_luma_q} < TH);
    sof  = vld_pipe_q[1] && s1_first_q;
    eof  = vld_pipe_q[1] && s1_last_q;
    // A start-of-frame pixel always begins from an empty box, dropping any partial frame.
    base   = sof ? BOX_INIT : acc_q;
    merged = base;
    if (fg) begin
      if (s1_x_q < base.xmin) merged.xmin = s1_x_q;
      if (s1_x_q > base.xmax) merged.xmax = s1_x_q;
      if (s1_y_q < base.ymin) merged.ymin = s1_y_q;
      if (s1_y_q > base.ymax) merged.ymax = s1_y_q;
      merged.cnt = base.cnt + 20'd1;
    end
  end

  // Frame FSM: next state, accumulator update and result publication.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    close       = 1'b0;
    box_valid_d = 1'b0;
    box_empty_d = box_empty_q;
    x_min_d     = x_min_q;
    x_max_d     = x_max_q;
    y_min_d     = y_min_q;
    y_max_d     = y_max_q;
    pix_count_d = pix_count_q;
    case (state_q)
      WAIT_SOF: begin
        // Accumulators stay at init until a frame start is seen.
        if (sof) begin
          state_d = TRACK;
          acc_d   = merged;
          close   = eof;
        end
      end
      TRACK: begin
        acc_d = merged;
        close = eof;
      end
    endcase
    // Close and clear share one edge so a back-to-back frame start is not lost.
    if (close) begin
      acc_d       = BOX_INIT;
      box_valid_d = 1'b1;
      box_empty_d = (merged.cnt < MIN_CNT);
      pix_count_d = merged.cnt;
      if (merged.cnt < MIN_CNT) begin
        x_min_d = '0;
        x_max_d = '0;
        y_min_d = '0;
        y_max_d = '0;
      end else begin
        x_min_d = merged.xmin;
        x_max_d = merged.xmax;
        y_min_d = merged.ymin;
        y_max_d = merged.ymax;
      end
    end
  end

  // Pipeline, state, accumulator and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_pipe_q  <= '0;
      s0_x_q      <= '0;
      s0_y_q      <= '0;
      s0_rgb_q    <= '0;
      s0_first_q  <= 1'b0;
      s0_last_q   <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_luma_q   <= '0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      state_q     <= WAIT_SOF;
      acc_q       <= BOX_INIT;
      bin_de_q    <= 1'b0;
      bin_q       <= 1'b0;
      bin_x_q     <= '0;
      bin_y_q     <= '0;
      box_valid_q <= 1'b0;
      box_empty_q <= 1'b0;
      x_min_q     <= '0;
      x_max_q     <= '0;
      y_min_q     <= '0;
      y_max_q     <= '0;
      pix_count_q <= '0;
    end else begin
      vld_pipe_q  <= {vld_pipe_q[0], s0_vld_d};
      s0_x_q      <= i_x;
      s0_y_q      <= i_y;
      s0_rgb_q    <= i_rgb;
      s0_first_q  <= s0_first_d;
      s0_last_q   <= s0_last_d;
      s1_x_q      <= s0_x_q;
      s1_y_q      <= s0_y_q;
      s1_luma_q   <= luma_sum[15:8];
      s1_first_q  <= s0_first_q;
      s1_last_q   <= s0_last_q;
      state_q     <= state_d;
      acc_q       <= acc_d;
      bin_de_q    <= vld_pipe_q[1];
      bin_q       <= fg;
      bin_x_q     <= s1_x_q;
      bin_y_q     <= s1_y_q;
      box_valid_q <= box_valid_d;
      box_empty_q <= box_empty_d;
      x_min_q     <= x_min_d;
      x_max_q     <= x_max_d;
      y_min_q     <= y_min_d;
      y_max_q     <= y_max_d;
      pix_count_q <= pix_count_d;
    end
  end

  assign o_bin_de    = bin_de_q;
  assign o_bin       = bin_q;
  assign o_bin_x     = bin_x_q;
  assign o_bin_y     = bin_y_q;
  assign o_box_valid = box_valid_q;
  assign o_box_empty = box_empty_q;
  assign o_x_min     = x_min_q;
  assign o_x_max     = x_max_q;
  assign o_y_min     = y_min_q;
  assign o_y_max     = y_max_q;
  assign o_pix_count = pix_count_q;

endmodule

// File: tb/tb_frame_bbox_tracker.sv
// Bench for frame_bbox_tracker on a reduced 32x12 raster.
module tb_frame_bbox_tracker;
  localparam int H = 32, V = 12, TH = 96, MINC = 16;

  logic        clk = 1'b0, rst = 1'b0, de = 1'b0;
  logic [10:0] xin = '0;
  logic [9:0]  yin = '0;
  logic [23:0] rgb = '0;
  logic        o_bin_de, o_bin, o_box_valid, o_box_empty;
  logic [10:0] o_bin_x, o_x_min, o_x_max;
  logic [9:0]  o_bin_y, o_y_min, o_y_max;
  logic [19:0] o_pix_count;

  frame_bbox_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .LUMA_TH(TH), .MIN_COUNT(MINC)) dut (
    .i_clk(clk), .i_rst(rst), .i_de(de), .i_x(xin), .i_y(yin), .i_rgb(rgb),
    .o_bin_de(o_bin_de), .o_bin(o_bin), .o_bin_x(o_bin_x), .o_bin_y(o_bin_y),
    .o_box_valid(o_box_valid), .o_box_empty(o_box_empty),
    .o_x_min(o_x_min), .o_x_max(o_x_max), .o_y_min(o_y_min), .o_y_max(o_y_max),
    .o_pix_count(o_pix_count));

  always #5 clk = ~clk;

  typedef struct {bit empty; int xmin; int xmax; int ymin; int ymax; int cnt;} res_t;
  typedef struct {bit de; bit bin; int x; int y; bit pulse; res_t pub;} exp_t;
  typedef struct {logic [23:0] rgb; bit exp_bin;} thr_t;

  int   checks = 0, failures = 0, pulses = 0, p0;
  res_t pub, cap;
  exp_t q[$];
  bit   started;
  int   fx[$], fy[$];
  int   bx0, bx1, by0, by1, nz_n;
  thr_t tbl[9];

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int luma_of(logic [23:0] c);
    return (77 * int'(c[23:16]) + 150 * int'(c[15:8]) + 29 * int'(c[7:0])) / 256;
  endfunction

  function automatic longint pack_res(res_t r);
    return (longint'(r.empty) << 62) | (longint'(r.xmin) << 51) | (longint'(r.xmax) << 40) |
           (longint'(r.ymin) << 30) | (longint'(r.ymax) << 20) | longint'(r.cnt);
  endfunction

  // Reference frame result: bbox and count taken over the list of foreground pixels.
  task automatic close_frame();
    int n = fx.size();
    pub.cnt = n;
    if (n < MINC) begin
      pub.empty = 1; pub.xmin = 0; pub.xmax = 0; pub.ymin = 0; pub.ymax = 0;
    end else begin
      pub.empty = 0; pub.xmin = H; pub.xmax = -1; pub.ymin = V; pub.ymax = -1;
      foreach (fx[i]) begin
        if (fx[i] < pub.xmin) pub.xmin = fx[i];
        if (fx[i] > pub.xmax) pub.xmax = fx[i];
        if (fy[i] < pub.ymin) pub.ymin = fy[i];
        if (fy[i] > pub.ymax) pub.ymax = fy[i];
      end
    end
    fx.delete(); fy.delete();
  endtask

  task automatic model_reset();
    exp_t b;
    q.delete(); fx.delete(); fy.delete(); started = 0;
    pub = '{0, 0, 0, 0, 0, 0};
    b = '{0, 0, 0, 0, 0, pub};
    q.push_back(b); q.push_back(b);
  endtask

  // Drive one pixel for one clock, update the model, compare the output due this cycle.
  task automatic step(bit d, int px, int py, logic [23:0] c);
    exp_t e, o;
    bit v, fg;
    de = d; xin = px[10:0]; yin = py[9:0]; rgb = c;
    v  = d && px < H && py < V;
    fg = v && luma_of(c) < TH;
    if (v && px == 0 && py == 0) begin started = 1; fx.delete(); fy.delete(); end
    if (started && fg) begin fx.push_back(px); fy.push_back(py); end
    e.pulse = 0;
    if (started && v && px == H-1 && py == V-1) begin close_frame(); e.pulse = 1; end
    e.de = v; e.bin = fg; e.x = px; e.y = py; e.pub = pub;
    q.push_back(e);
    @(posedge clk); #1;
    o = q.pop_front();
    chk("bin_de", longint'(o_bin_de), longint'(o.de));
    if (o.de) begin
      chk("bin", longint'(o_bin), longint'(o.bin));
      chk("bin_xy", longint'({o_bin_x, o_bin_y}), (longint'(o.x) << 10) | longint'(o.y));
    end
    chk("box_valid", longint'(o_box_valid), longint'(o.pulse));
    chk("result", longint'({o_box_empty, o_x_min, o_x_max, o_y_min, o_y_max, o_pix_count}),
        pack_res(o.pub));
    if (o_box_valid) begin
      pulses++;
      cap = '{o_box_empty, int'(o_x_min), int'(o_x_max), int'(o_y_min), int'(o_y_max),
              int'(o_pix_count)};
    end
  endtask

  task automatic bubble();
    case ($urandom_range(0, 2))
      0:       step(1'b0, int'($urandom_range(0, H-1)), int'($urandom_range(0, V-1)), 24'h0);
      1:       step(1'b1, H + int'($urandom_range(0, 50)), int'($urandom_range(0, V-1)), 24'h0);
      default: step(1'b1, int'($urandom_range(0, H-1)), V + int'($urandom_range(0, 50)), 24'h0);
    endcase
  endtask

  task automatic flush();
    for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 24'hFFFFFF);
  endtask

  function automatic logic [23:0] img(int xx, int yy, bit rnd);
    if (xx >= bx0 && xx <= bx1 && yy >= by0 && yy <= by1) return 24'h000000;
    for (int i = 0; i < nz_n; i++)
      if (xx == 1 + 2*i && yy == 1 + (i % 10)) return 24'h000000;
    return rnd ? 24'($urandom) : 24'hFFFFFF;
  endfunction

  // Raster rows [ys, ye); never inserts bubbles ahead of the frame-start pixel.
  task automatic drive_frame(int bub, bit rnd, int ys, int ye);
    for (int yy = ys; yy < ye; yy++)
      for (int xx = 0; xx < H; xx++) begin
        if (!(xx == 0 && yy == 0))
          for (int k = 0; k < 3 && int'($urandom_range(0, 99)) < bub; k++) bubble();
        step(1'b1, xx, yy, img(xx, yy, rnd));
      end
  endtask

  task automatic set_box(int a, int b, int c, int d);
    bx0 = a; bx1 = b; by0 = c; by1 = d; nz_n = 0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_bin"}, longint'({o_bin_de, o_bin, o_bin_x, o_bin_y}), 0);
    chk({tag, "_box"}, longint'({o_box_valid, o_box_empty, o_x_min, o_x_max, o_y_min, o_y_max,
                                 o_pix_count}), 0);
  endtask

  task automatic chk_cap(string tag, int e, int x0, int x1, int y0, int y1, int n);
    chk({tag, "_empty"}, longint'(cap.empty), longint'(e));
    chk({tag, "_x"}, (longint'(cap.xmin) << 16) | longint'(cap.xmax), (longint'(x0) << 16) | longint'(x1));
    chk({tag, "_y"}, (longint'(cap.ymin) << 16) | longint'(cap.ymax), (longint'(y0) << 16) | longint'(y1));
    chk({tag, "_count"}, longint'(cap.cnt), longint'(n));
  endtask

  initial begin
    tbl[0] = '{24'h606060, 1'b0};  // luma 96
    tbl[1] = '{24'h5F5F5F, 1'b1};  // luma 95
    tbl[2] = '{24'h000000, 1'b1};
    tbl[3] = '{24'hFFFFFF, 1'b0};
    tbl[4] = '{24'hFF0000, 1'b1};  // luma 76
    tbl[5] = '{24'h00FF00, 1'b0};  // luma 149
    tbl[6] = '{24'h0000FF, 1'b1};  // luma 28
    tbl[7] = '{24'h808080, 1'b0};  // luma 128
    tbl[8] = '{24'h404040, 1'b1};  // luma 64
    set_box(1, 0, 1, 0);
    cap = '{0, 0, 0, 0, 0, 0};

    // Reset state.
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst = 1'b0;
    model_reset();

    // Threshold table, binarizer active while still waiting for a frame start.
    foreach (tbl[i]) begin
      step(1'b1, 5, 3, tbl[i].rgb);
      step(1'b0, 0, 0, 24'hFFFFFF);
      step(1'b0, 0, 0, 24'hFFFFFF);
      chk("thr_de", longint'(o_bin_de), 1);
      chk("thr_bin", longint'(o_bin), longint'(tbl[i].exp_bin));
    end

    // Dark block on white.
    set_box(10, 19, 3, 6);
    p0 = pulses;
    drive_frame(0, 0, 0, V); flush();
    chk("blk_pulses", longint'(pulses - p0), 1);
    chk_cap("blk", 0, 10, 19, 3, 6, 40);

    // Noise rejection: 15 isolated pixels empty, 16 not.
    set_box(1, 0, 1, 0); nz_n = 15;
    p0 = pulses;
    drive_frame(20, 0, 0, V); flush();
    chk("nz15_pulses", longint'(pulses - p0), 1);
    chk_cap("nz15", 1, 0, 0, 0, 0, 15);
    nz_n = 16;
    drive_frame(20, 0, 0, V); flush();
    chk_cap("nz16", 0, 1, 31, 1, 10, 16);

    // Back-to-back frames with bubbles, no gap at the frame boundary.
    p0 = pulses;
    set_box(2, 5, 1, 2);   drive_frame(30, 0, 0, V);
    set_box(20, 28, 7, 10); drive_frame(30, 0, 0, V); flush();
    chk("b2b_pulses", longint'(pulses - p0), 2);
    chk_cap("b2b", 0, 20, 28, 7, 10, 36);

    // Truncated frame followed by a full frame.
    p0 = pulses;
    set_box(2, 5, 1, 2);   drive_frame(10, 0, 0, 5);
    set_box(20, 28, 7, 10); drive_frame(10, 0, 0, V); flush();
    chk("trunc_pulses", longint'(pulses - p0), 1);
    chk_cap("trunc", 0, 20, 28, 7, 10, 36);

    // Reset mid-frame: tail with last pixel reports nothing, next full frame reports once.
    drive_frame(10, 0, 0, 6);
    rst = 1'b1;
    #1 chk_zero("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    model_reset();
    p0 = pulses;
    drive_frame(10, 0, 6, V); flush();
    chk("tail_pulses", longint'(pulses - p0), 0);
    set_box(2, 5, 1, 2); drive_frame(10, 0, 0, V); flush();
    chk("post_rst_pulses", longint'(pulses - p0), 1);
    chk_cap("post_rst", 1, 0, 0, 0, 0, 8);

    // Randomized frames against the model.
    for (int f = 0; f < 5; f++) begin
      int a = int'($urandom_range(0, H-1));
      int c = int'($urandom_range(0, V-1));
      set_box(a, a + int'($urandom_range(0, H-1-a)), c, c + int'($urandom_range(0, V-1-c)));
      drive_frame(25, 1'b1, (f == 3) ? 4 : 0, V);
    end
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
